// File: rtl/unidade_controle_multiciclo_if.sv
// ----------------------------------------------------------------------------
// unidade_controle_multiciclo_if
//   Bundle between the multi-cycle control FSM and the RV64 datapath
//   (PC, IR, ula64, register file, data memory).
//
//   Datapath -> control (status):
//     opcode[6:0]   IR[6:0]
//     funct3[2:0]   IR[14:12]
//     funct7_5      IR[30]
//     igual         ULA equal flag (A == B)
//     mem_rdy       memory finished the current read/write this cycle
//   Control -> datapath (commands):
//     reset_wire    datapath register reset
//     pcWrite       PC load enable
//     pcSrc         PC source: 0 ULA result, 1 ALUOut
//     irWrite       IR load enable
//     memRead       memory read request
//     memWrite      memory write request
//     iOrD          memory address: 0 PC, 1 ALUOut
//     writeReg      register file write enable
//     memToReg[1:0] writeback source: 0 ALUOut, 1 MDR, 2 immediate
//     loadAB        latch register file outputs into A/B
//     loadAluOut    latch ULA result into ALUOut
//     aluSrcA       ULA A input: 0 PC, 1 A
//     aluSrcB[1:0]  ULA B input: 0 B, 1 const 4, 2 imm, 3 imm<<1
//     operacao[2:0] ULA selector
//     estado[3:0]   current FSM state (debug)
//     erro          FSM is in the sticky error state
//
//   Modports: master = control unit, slave = datapath side.
// ----------------------------------------------------------------------------
interface unidade_controle_multiciclo_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       igual;
    logic       mem_rdy;

    logic       reset_wire;
    logic       pcWrite;
    logic       pcSrc;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       writeReg;
    logic [1:0] memToReg;
    logic       loadAB;
    logic       loadAluOut;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] operacao;
    logic [3:0] estado;
    logic       erro;

    modport master (
        input  opcode, funct3, funct7_5, igual, mem_rdy,
        output reset_wire, pcWrite, pcSrc, irWrite, memRead, memWrite, iOrD,
               writeReg, memToReg, loadAB, loadAluOut, aluSrcA, aluSrcB,
               operacao, estado, erro
    );

    modport slave (
        output opcode, funct3, funct7_5, igual, mem_rdy,
        input  reset_wire, pcWrite, pcSrc, irWrite, memRead, memWrite, iOrD,
               writeReg, memToReg, loadAB, loadAluOut, aluSrcA, aluSrcB,
               operacao, estado, erro
    );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// ----------------------------------------------------------------------------
// unidade_controle_multiciclo
//   Multi-cycle control FSM for the RV64 datapath. Sequences fetch, decode,
//   execute, memory access and writeback, issuing write enables, mux selects
//   and the ULA selector. Memory accesses use a req/ready handshake, so the
//   FSM stretches to any memory latency.
//
//   Ports:
//     CLK  rising-edge clock
//     RST  asynchronous active-high reset
//     bus  unidade_controle_multiciclo_if.master (status in, commands out)
//
//   Parameter:
//     MEM_TIMEOUT  max cycles a memory request may wait for mem_rdy before
//                  the FSM gives up and enters ERRO (timeout build only)
//
//   Build option:
//     MEM_TIMEOUT_EN  when defined, a wait counter watches FETCH/MEM_LD/
//                     MEM_ST; when undefined the FSM waits forever.
// ----------------------------------------------------------------------------
module unidade_controle_multiciclo #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                           CLK,
    input  logic                           RST,
    unidade_controle_multiciclo_if.master  bus
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_EXEC_I = 4'd4;
    localparam logic [3:0] S_ADDR   = 4'd5;
    localparam logic [3:0] S_MEM_LD = 4'd6;
    localparam logic [3:0] S_MEM_ST = 4'd7;
    localparam logic [3:0] S_WB     = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ERRO   = 4'd10;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ULA_ADD = 3'b001;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [2:0] ULA_AND = 3'b011;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [1:0] r_wb_sel;
    logic       w_timeout;

    logic       w_reset_wire;
    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_ir_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_i_or_d;
    logic       w_write_reg;
    logic [1:0] w_mem_to_reg;
    logic       w_load_ab;
    logic       w_load_alu_out;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_operacao;
    logic       w_erro;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_waiting;

    // A request is waiting when the FSM sits in a memory state without ready.
    // mem_rdy on the same cycle the count hits the limit still completes.
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_LD) ||
                        (r_state == S_MEM_ST)) && !bus.mem_rdy;
    assign w_timeout = w_waiting && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_wait_cnt <= '0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_unused_cfg = (MEM_TIMEOUT != 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_RESET;
            r_wb_sel <= 2'd0;
        end else begin
            r_state <= w_next_state;
            // Writeback source is fixed at dispatch so WB stays purely Moore.
            if (r_state == S_DECODE) begin
                if (bus.opcode == OP_LUI) begin
                    r_wb_sel <= 2'd2;
                end else if (bus.opcode == OP_LD) begin
                    r_wb_sel <= 2'd1;
                end else begin
                    r_wb_sel <= 2'd0;
                end
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_reset_wire   = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src       = 1'b0;
        w_ir_write     = 1'b0;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_i_or_d       = 1'b0;
        w_write_reg    = 1'b0;
        w_mem_to_reg   = 2'd0;
        w_load_ab      = 1'b0;
        w_load_alu_out = 1'b0;
        w_alu_src_a    = 1'b0;
        w_alu_src_b    = 2'd0;
        w_operacao     = 3'b000;
        w_erro         = 1'b0;

        case (r_state)
            S_RESET: begin
                w_reset_wire = 1'b1;
                w_next_state = S_FETCH;
            end

            // PC+4 is computed in the ULA while the fetch is in flight.
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'd1;
                w_operacao  = ULA_ADD;
                if (bus.mem_rdy) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_ERRO;
                end
            end

            // Branch target (PC + imm<<1) is precomputed into ALUOut here.
            S_DECODE: begin
                w_load_ab      = 1'b1;
                w_alu_src_b    = 2'd3;
                w_operacao     = ULA_ADD;
                w_load_alu_out = 1'b1;
                case (bus.opcode)
                    OP_R:         w_next_state = S_EXEC_R;
                    OP_I:         w_next_state = S_EXEC_I;
                    OP_LD, OP_ST: w_next_state = S_ADDR;
                    OP_BR:        w_next_state = S_BRANCH;
                    OP_LUI:       w_next_state = S_WB;
                    default:      w_next_state = S_ERRO;
                endcase
            end

            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'd0;
                if (bus.funct3 == 3'b000) begin
                    w_operacao     = bus.funct7_5 ? ULA_SUB : ULA_ADD;
                    w_load_alu_out = 1'b1;
                    w_next_state   = S_WB;
                end else if (bus.funct3 == 3'b111) begin
                    w_operacao     = ULA_AND;
                    w_load_alu_out = 1'b1;
                    w_next_state   = S_WB;
                end else begin
                    w_next_state = S_ERRO;
                end
            end

            S_EXEC_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'd2;
                w_operacao  = ULA_ADD;
                if (bus.funct3 == 3'b000) begin
                    w_load_alu_out = 1'b1;
                    w_next_state   = S_WB;
                end else begin
                    w_next_state = S_ERRO;
                end
            end

            S_ADDR: begin
                w_alu_src_a    = 1'b1;
                w_alu_src_b    = 2'd2;
                w_operacao     = ULA_ADD;
                w_load_alu_out = 1'b1;
                w_next_state   = (bus.opcode == OP_LD) ? S_MEM_LD : S_MEM_ST;
            end

            S_MEM_LD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (bus.mem_rdy) begin
                    w_next_state = S_WB;
                end else if (w_timeout) begin
                    w_next_state = S_ERRO;
                end
            end

            S_MEM_ST: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (bus.mem_rdy) begin
                    w_next_state = S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_ERRO;
                end
            end

            S_WB: begin
                w_write_reg  = 1'b1;
                w_mem_to_reg = r_wb_sel;
                w_next_state = S_FETCH;
            end

            // Only beq/bne are supported; funct3[0] inverts the equality test.
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'd0;
                w_operacao  = ULA_SUB;
                if (bus.funct3[2:1] != 2'b00) begin
                    w_next_state = S_ERRO;
                end else begin
                    if (bus.igual ^ bus.funct3[0]) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 1'b1;
                    end
                    w_next_state = S_FETCH;
                end
            end

            S_ERRO: begin
                w_erro = 1'b1;
            end

            default: begin
                w_next_state = S_ERRO;
            end
        endcase
    end

    assign bus.reset_wire = w_reset_wire;
    assign bus.pcWrite    = w_pc_write;
    assign bus.pcSrc      = w_pc_src;
    assign bus.irWrite    = w_ir_write;
    assign bus.memRead    = w_mem_read;
    assign bus.memWrite   = w_mem_write;
    assign bus.iOrD       = w_i_or_d;
    assign bus.writeReg   = w_write_reg;
    assign bus.memToReg   = w_mem_to_reg;
    assign bus.loadAB     = w_load_ab;
    assign bus.loadAluOut = w_load_alu_out;
    assign bus.aluSrcA    = w_alu_src_a;
    assign bus.aluSrcB    = w_alu_src_b;
    assign bus.operacao   = w_operacao;
    assign bus.estado     = r_state;
    assign bus.erro       = w_erro;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// ----------------------------------------------------------------------------
// tb_unidade_controle_multiciclo
//   Directed and randomized instruction sequences for the multi-cycle control
//   unit. A per-instruction reference model derives, from the instruction
//   class and memory wait profile, how many cycles the instruction takes and
//   which enables must fire how often; the bench tallies the DUT's enables
//   over that window and compares the totals.
// ----------------------------------------------------------------------------
module tb_unidade_controle_multiciclo;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    unidade_controle_multiciclo_if bus();

    unidade_controle_multiciclo #(.MEM_TIMEOUT(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All enables/flags that must be low while reset is in effect.
    function automatic logic [9:0] enables();
        return {bus.pcWrite, bus.irWrite, bus.memRead, bus.memWrite, bus.writeReg,
                bus.loadAB, bus.loadAluOut, bus.erro, bus.pcSrc, bus.iOrD};
    endfunction

    function automatic logic [8:0] fetch_sig();
        return {bus.reset_wire, bus.memRead, bus.iOrD, bus.aluSrcA, bus.aluSrcB, bus.operacao};
    endfunction

    localparam logic [8:0] FETCH_SIG = {1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b001};

    task automatic do_reset(input logic rdy, input string tag);
        @(negedge CLK);
        RST = 1'b1;
        bus.mem_rdy = rdy;
        #1;
        chk({tag, "/held_rw"}, 32'(bus.reset_wire), 32'd1);
        chk({tag, "/held_en"}, 32'(enables()), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk({tag, "/rel_rw"}, 32'(bus.reset_wire), 32'd1);
        chk({tag, "/rel_en"}, 32'(enables()), 32'd0);
    endtask

    // One instruction starting in FETCH. fw = fetch wait cycles, lw = data
    // memory wait cycles (ld/sd only).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic ig, input int fw, input int lw, input string tag);
        int   total, ms, tail;
        bit   is_ld, is_st, is_r, is_i, is_br, is_lui, take;
        int   e_pcw, e_pcs, e_wr, e_m2r, e_rd, e_mw, e_iord, e_op;
        int   pcw, pcs, irw, wr, m2r, rd, mw, iord, both, opv, err;
        logic rdy;

        is_r   = (op == OP_R);
        is_i   = (op == OP_I);
        is_ld  = (op == OP_LD);
        is_st  = (op == OP_ST);
        is_br  = (op == OP_BR);
        is_lui = (op == OP_LUI);
        take   = is_br && (ig ^ f3[0]);

        // Fetch (fw+1) + decode, then class-dependent tail.
        if (is_r || is_i)  tail = 2;
        else if (is_ld)    tail = lw + 3;
        else if (is_st)    tail = lw + 2;
        else               tail = 1;
        total = fw + 2 + tail;
        ms    = fw + 3;

        e_pcw  = 1 + (take ? 1 : 0);
        e_pcs  = take ? 1 : 0;
        e_wr   = (is_r || is_i || is_ld || is_lui) ? 1 : 0;
        e_m2r  = is_ld ? 1 : (is_lui ? 2 : (e_wr == 1 ? 0 : 3));
        e_rd   = fw + 1 + (is_ld ? lw + 1 : 0);
        e_mw   = is_st ? lw + 1 : 0;
        e_iord = (is_ld || is_st) ? lw + 1 : 0;
        if (is_r)        e_op = (f3 == 3'b000) ? (f75 ? 2 : 1) : 3;
        else if (is_br)  e_op = 2;
        else if (is_lui) e_op = 7;
        else             e_op = 1;

        pcw = 0; pcs = 0; irw = 0; wr = 0; m2r = 3; rd = 0; mw = 0;
        iord = 0; both = 0; opv = 7; err = 0;

        for (int c = 0; c < total; c++) begin
            if (c <= fw)                                      rdy = (c == fw);
            else if ((is_ld || is_st) && c >= ms && c <= ms + lw) rdy = (c == ms + lw);
            else                                              rdy = 1'($urandom_range(0, 1));
            @(negedge CLK);
            bus.mem_rdy = rdy;
            if (c <= fw) begin
                bus.opcode   = 7'($urandom_range(0, 127));
                bus.funct3   = 3'($urandom_range(0, 7));
                bus.funct7_5 = 1'($urandom_range(0, 1));
                bus.igual    = 1'($urandom_range(0, 1));
            end else begin
                bus.opcode   = op;
                bus.funct3   = f3;
                bus.funct7_5 = f75;
                bus.igual    = ig;
            end
            #1;
            if (c == 0) chk({tag, "/fetch"}, 32'(fetch_sig()), 32'(FETCH_SIG));
            pcw  += int'(bus.pcWrite);
            pcs  += int'(bus.pcWrite & bus.pcSrc);
            irw  += int'(bus.irWrite);
            wr   += int'(bus.writeReg);
            rd   += int'(bus.memRead);
            mw   += int'(bus.memWrite);
            iord += int'(bus.iOrD & (bus.memRead | bus.memWrite));
            both += int'(bus.memRead & bus.memWrite);
            err  += int'(bus.erro);
            if (bus.writeReg) m2r = int'(bus.memToReg);
            if (bus.aluSrcA)  opv = int'(bus.operacao);
        end

        chk({tag, "/pcWrite"},  32'(pcw),  32'(e_pcw));
        chk({tag, "/pcSrc1"},   32'(pcs),  32'(e_pcs));
        chk({tag, "/irWrite"},  32'(irw),  32'd1);
        chk({tag, "/writeReg"}, 32'(wr),   32'(e_wr));
        chk({tag, "/memToReg"}, 32'(m2r),  32'(e_m2r));
        chk({tag, "/memRead"},  32'(rd),   32'(e_rd));
        chk({tag, "/memWrite"}, 32'(mw),   32'(e_mw));
        chk({tag, "/iOrD"},     32'(iord), 32'(e_iord));
        chk({tag, "/rd_wr"},    32'(both), 32'd0);
        chk({tag, "/operacao"}, 32'(opv),  32'(e_op));
        chk({tag, "/erro"},     32'(err),  32'd0);
    endtask

    // Illegal instruction: erro must first appear at cycle k_err and stay
    // for ten cycles with no side effects.
    task automatic run_err(input logic [6:0] op, input logic [2:0] f3, input int k_err,
                           input string tag);
        int errs, side;
        errs = 0; side = 0;
        for (int c = 0; c < k_err + 10; c++) begin
            @(negedge CLK);
            bus.mem_rdy  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.opcode   = op;
            bus.funct3   = f3;
            bus.funct7_5 = 1'b0;
            bus.igual    = 1'($urandom_range(0, 1));
            #1;
            if (c == k_err - 1) chk({tag, "/pre"}, 32'(bus.erro), 32'd0);
            if (c >= k_err) begin
                errs += int'(bus.erro);
                side += int'(bus.pcWrite | bus.writeReg | bus.memRead | bus.memWrite |
                             bus.irWrite | bus.loadAluOut);
            end
        end
        chk({tag, "/erro_cycles"}, 32'(errs), 32'd10);
        chk({tag, "/side"},        32'(side), 32'd0);
        do_reset(1'b0, {tag, "/rst"});
    endtask

    initial begin
        int   k, fw, lw, rdcnt, errcnt;
        logic [6:0] op;
        logic [2:0] f3;
        logic f75, ig;

        bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0;
        bus.igual  = 1'b0; bus.mem_rdy = 1'b0;

        do_reset(1'b0, "por");

        // Directed instructions
        run_instr(OP_R,   3'b000, 1'b0, 1'b0, 0, 0, "add");
        run_instr(OP_R,   3'b000, 1'b1, 1'b0, 1, 0, "sub");
        run_instr(OP_R,   3'b111, 1'b0, 1'b1, 0, 0, "and");
        run_instr(OP_I,   3'b000, 1'b0, 1'b0, 0, 0, "addi");
        run_instr(OP_LD,  3'b011, 1'b0, 1'b0, 0, 3, "ld_wait3");
        run_instr(OP_LD,  3'b011, 1'b0, 1'b0, 0, 0, "ld");
        run_instr(OP_ST,  3'b011, 1'b0, 1'b0, 0, 0, "sd");
        run_instr(OP_ST,  3'b011, 1'b0, 1'b0, 2, 2, "sd_wait");
        run_instr(OP_BR,  3'b000, 1'b0, 1'b1, 0, 0, "beq_taken");
        run_instr(OP_BR,  3'b001, 1'b0, 1'b1, 0, 0, "bne_not");
        run_instr(OP_BR,  3'b001, 1'b0, 1'b0, 0, 0, "bne_taken");
        run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0, "lui");

        // Reset in the middle of a fetch, with mem_rdy high during reset
        @(negedge CLK);
        bus.mem_rdy = 1'b0;
        #1;
        chk("abort_fetch/pre", 32'(bus.memRead), 32'd1);
        do_reset(1'b1, "abort_fetch");

        // Randomized instruction stream
        for (int n = 0; n < 30; n++) begin
            k   = int'($urandom_range(0, 5));
            fw  = int'($urandom_range(0, 3));
            lw  = int'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            f75 = 1'($urandom_range(0, 1));
            ig  = 1'($urandom_range(0, 1));
            case (k)
                0: begin op = OP_R; f3 = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000; end
                1: begin op = OP_I; f3 = 3'b000; end
                2: op = OP_LD;
                3: op = OP_ST;
                4: begin op = OP_BR; f3 = {2'b00, 1'($urandom_range(0, 1))}; end
                default: op = OP_LUI;
            endcase
            run_instr(op, f3, f75, ig, fw, lw, $sformatf("rnd%0d", n));
        end

        // Reset while a store is waiting for memory
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, "pre_abort");
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            bus.mem_rdy = (c == 0);
            bus.opcode  = OP_ST;
            #1;
        end
        chk("abort_store/pre", 32'(bus.memWrite), 32'd1);
        do_reset(1'b1, "abort_store");

        // Memory never answers in FETCH
        rdcnt = 0; errcnt = 0;
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            bus.mem_rdy = 1'b0;
            #1;
            rdcnt  += int'(bus.memRead);
            errcnt += int'(bus.erro);
        end
        chk("timeout/wait_rd", 32'(rdcnt), 32'd16);
        chk("timeout/wait_err", 32'(errcnt), 32'd0);
        @(negedge CLK);
        #1;
        chk("timeout/erro", 32'({bus.erro, bus.memRead}), 32'b10);
        do_reset(1'b0, "timeout_rst");
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            bus.mem_rdy = (c == 15);
            bus.opcode  = OP_R;
            #1;
        end
        @(negedge CLK);
        bus.mem_rdy = 1'b0;
        #1;
        chk("timeout/late_rdy", 32'({bus.loadAB, bus.erro}), 32'b10);
        do_reset(1'b0, "late_rdy_rst");
`else
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            bus.mem_rdy = 1'b0;
            #1;
            rdcnt  += int'(bus.memRead);
            errcnt += int'(bus.erro);
        end
        chk("stuck/memRead", 32'(rdcnt), 32'd40);
        chk("stuck/erro", 32'(errcnt), 32'd0);
        @(negedge CLK);
        bus.mem_rdy = 1'b1;
        bus.opcode  = OP_R;
        #1;
        chk("stuck/irWrite", 32'({bus.irWrite, bus.pcWrite}), 32'b11);
        @(negedge CLK);
        #1;
        chk("stuck/decode", 32'(bus.loadAB), 32'd1);
        do_reset(1'b0, "stuck_rst");
`endif

        // Illegal encodings
        run_err(7'b1111111, 3'b000, 2, "bad_opcode");
        run_err(OP_R,       3'b010, 3, "bad_r_f3");
        run_err(OP_I,       3'b001, 3, "bad_i_f3");
        run_err(OP_BR,      3'b100, 3, "bad_br_f3");

        // Machine still works after the error recoveries
        run_instr(OP_LD, 3'b011, 1'b0, 1'b0, 1, 1, "final_ld");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
